ram_req_ctrl: RTL and testbench
===============================

Name: ram_req_ctrl

Overview:
Request/response front-end that sits directly upstream of the team's single-port synchronous RAM and owns its we/addr/din pins. It accepts read/write requests over valid/ready and issues one RAM access per accepted request. For reads it returns the RAM's registered dout over a valid/ready response channel, holding it stable under backpressure. Sustains one access per cycle when the response channel is not stalled.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM data width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data present
rsp_ready  in  1  consumer takes data
rsp_rdata  out  DATA_WIDTH  read data
ram_we  out  1  to RAM we
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_din  out  DATA_WIDTH  to RAM din
ram_dout  in  DATA_WIDTH  from RAM dout; updated on every non-write edge, held on write edges
busy  out  1  high while the init sweep runs (optional feature); otherwise 0

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE (INIT when the optional feature is compiled in), rsp_valid = 0, the latched address = 0, busy = 0 (1 when the feature is in). rsp_rdata is don't-care while rsp_valid = 0.
- States:
  - IDLE: req_ready = 1.
  - RSP: read result pending; rsp_valid = 1; req_ready = rsp_ready.
  - INIT: only with the optional feature.
- Accept: acc = req_valid & req_ready.
- RAM drive (combinational):
  - When acc: ram_addr = req_addr, ram_we = req_we, ram_din = req_wdata.
  - Otherwise: ram_addr = the latched address, ram_we = 0, ram_din = 0.
  - Holding ram_addr at the latched address keeps ram_dout stable while stalled in RSP.
- Accepted write: the RAM writes at the same edge. No response is generated. The next state is IDLE.
- Accepted read: the address is latched. The next state is RSP. rsp_valid rises the cycle after acceptance, giving latency 1.
- Read data path: rsp_rdata = ram_dout, combinational, valid whenever rsp_valid = 1.
- In RSP:
  - rsp_ready = 0: stay in RSP; rsp_rdata stays constant.
  - rsp_ready = 1 with no new request: go to IDLE.
  - rsp_ready = 1 with a new request: the response completes and the new request is accepted in the same cycle (back-to-back).
- Read-after-write to the same address, back-to-back: the read returns the new data.
- Write accepted while leaving RSP: the RAM holds dout on the write edge. rsp_valid drops.
- rsp_valid never drops without rsp_ready, except on reset.
- Reset mid-operation: a pending response is discarded and rsp_valid drops immediately. RAM contents are untouched, except that the optional feature re-clears them.
- Outputs never depend combinationally on rsp_ready, except req_ready in RSP and ram_* through acc.

Optional Feature:
RAM_CTRL_CLEAR_EN
- Defined:
  - After reset the block enters INIT with sweep counter = 0. Each cycle it drives ram_we = 1, ram_addr = counter, ram_din = 0, and increments the counter.
  - After writing DEPTH-1 it moves to IDLE. INIT lasts exactly DEPTH cycles.
  - During INIT: req_ready = 0, rsp_valid = 0, busy = 1.
- Undefined: no INIT state and no counter; busy is tied to 0; RAM contents after power-up are undefined.

Decomposition:
- Shared package ram_pkg: state enum {INIT, IDLE, RSP}, default ADDR_WIDTH/DATA_WIDTH constants, and a DEPTH helper function.
- Sub-module: none required. A counter sub-module ram_init_seq is natural if the sweep is reused by other RAM front-ends.

Test Plan (ADDR_WIDTH = 4, DATA_WIDTH = 8, the team's RAM model attached):
- Write 0x3C to address 5, then read address 5 with rsp_ready = 1 -> rsp_valid one cycle after the read is accepted, rsp_rdata = 0x3C; no response is generated for the write.
- Back-to-back reads of addresses 1, 2, 3 (preloaded 0x11, 0x22, 0x33) with rsp_ready held at 1 -> req_ready stays 1; responses arrive 0x11, 0x22, 0x33 on consecutive cycles.
- Read address 7 (0xA5) with rsp_ready = 0 for 4 cycles, while the next request (write 0xFF to address 7) is held valid -> req_ready = 0 and rsp_rdata = 0xA5 stable for all 4 cycles; the write is accepted on the rsp_ready cycle; a later read returns 0xFF.
- Assert rst_n low while rsp_valid = 1 -> rsp_valid = 0 immediately, with no clock edge needed; after release the block is in IDLE with req_ready = 1, or in INIT when the feature is in.
- With RAM_CTRL_CLEAR_EN, preload 0x5A everywhere, then reset -> busy = 1 and req_ready = 0 for exactly 16 cycles; afterwards reads of addresses 0..15 all return 0x00.
- Read address 9 immediately followed by write 0x77 to address 9, with rsp_ready = 1 -> the first response returns the old value; a subsequent read returns 0x77.

Source files
------------

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and constants for the RAM request front-end.
package ram_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RSP
  } state_e;

  function automatic int unsigned ram_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_req_ctrl.sv
// Valid/ready request front-end owning a single-port synchronous RAM's pins.
// Define RAM_CTRL_CLEAR_EN to zero the whole RAM with an INIT sweep after reset.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    acc;

`ifdef RAM_CTRL_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ram_depth(ADDR_WIDTH) - 1);
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_din     = '0;
`ifdef RAM_CTRL_CLEAR_EN
    cnt_d       = cnt_q;
    busy_d      = busy_q;
`endif
    case (state_q)
      INIT: begin
`ifdef RAM_CTRL_CLEAR_EN
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      IDLE: req_ready = 1'b1;
      RSP: begin
        req_ready = rsp_ready;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    acc = req_valid & req_ready;
    // Outside an accept, ram_addr stays on the latched read address so dout holds under stall.
    if (acc) begin
      ram_we   = req_we;
      ram_addr = req_addr;
      ram_din  = req_wdata;
      if (req_we) begin
        state_d = IDLE;
      end else begin
        addr_d  = req_addr;
        state_d = RSP;
      end
    end
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_CTRL_CLEAR_EN
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
`else
      state_q <= IDLE;
`endif
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
`ifdef RAM_CTRL_CLEAR_EN
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`endif
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = ram_dout;

`ifdef RAM_CTRL_CLEAR_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Randomized self-checking bench for ram_req_ctrl against a memory-array reference model.
module tb_ram_req_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  // Single-port synchronous RAM: dout updates on non-write edges, holds on write edges.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_chk = 0;
  int unsigned   n_bad = 0;

  // Reference model: contents the RAM should hold, plus one outstanding read slot.
  logic [DW-1:0] shadow [DEPTH];
  bit            pending;
  logic [DW-1:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit rr);
    bit exp_ready;
    bit acc;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    #1;
    exp_ready = !pending || rr;
    acc       = v && exp_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, 0);
    chk("ram_we", ram_we, acc && we);
    if (acc) chk("ram_addr", ram_addr, a);
    if (acc && we) chk("ram_din", ram_din, d);
    @(posedge clk);
    if (pending && rr) pending = 0;
    if (acc) begin
      if (we) shadow[a] = d;
      else begin
        pending  = 1;
        exp_data = shadow[a];
      end
    end
    @(negedge clk);
    chk("rsp_valid", rsp_valid, pending);
    if (pending) chk("rsp_rdata", rsp_rdata, exp_data);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(1, 1, a, d, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1, 0, a, '0, 1);
  endtask

  task automatic idle(input bit rr);
    cycle(0, 0, '0, '0, rr);
  endtask

  // Called right after reset release at a falling edge.
  task automatic after_reset;
    pending = 0;
`ifdef RAM_CTRL_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_busy", busy, 1);
      chk("init_req_ready", req_ready, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    pending   = 0;
    exp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
`ifdef RAM_CTRL_CLEAR_EN
    chk("rst_busy", busy, 1);
`else
    chk("rst_busy", busy, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    after_reset();

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom));

    wr(4'd5, 8'h3C);
    rd(4'd5);
    idle(1);

    wr(4'd1, 8'h11);
    wr(4'd2, 8'h22);
    wr(4'd3, 8'h33);
    rd(4'd1);
    rd(4'd2);
    rd(4'd3);
    idle(1);

    wr(4'd7, 8'hA5);
    rd(4'd7);
    repeat (4) cycle(1, 1, 4'd7, 8'hFF, 0);
    cycle(1, 1, 4'd7, 8'hFF, 1);
    rd(4'd7);
    idle(1);

    wr(4'd9, 8'h42);
    rd(4'd9);
    wr(4'd9, 8'h77);
    rd(4'd9);
    idle(1);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom),
            DW'($urandom), $urandom_range(0, 2) != 0);

`ifdef RAM_CTRL_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'h5A);
`endif
    rd(4'd3);
    cycle(0, 0, '0, '0, 0);
    chk("pre_reset_rsp_valid", rsp_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    after_reset();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(1);
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom),
            DW'($urandom), $urandom_range(0, 2) != 0);
    idle(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
